// File: rtl/ethernet_sys_ram_arb_pkg.sv
// Shared types and constants for the NIOS data RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ethernet_sys_ram_arb_pkg;

   localparam int RD_LATENCY  = 1;
   localparam int BURST_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_M0 = 2'd1,
      OWN_M1 = 2'd2
   } arb_state_t;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } mst_idx_t;

   typedef logic [BURST_CNT_W-1:0] burst_cnt_t;

endpackage

// File: rtl/ethernet_sys_ram_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters, the arbiter and the RAM wrapper.
// Latency: n/a (wiring only).
// Backpressure: mN_waitrequest from the arbiter; the RAM side has none.
// Ports: m0_* / m1_* master request and response signals, ram_* RAM wrapper signals.
// Modport slave is the arbiter's view; modport master is the system/bench view.
interface ethernet_sys_ram_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
);
   logic [ADDR_W-1:0] m0_address,    m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read,       m1_read;
   logic              m0_write,      m1_write;
   logic [DATA_W-1:0] m0_writedata,  m1_writedata;
   logic              m0_waitrequest,   m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata,      m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;

   logic [ADDR_W-1:0] ram_address;
   logic [BE_W-1:0]   ram_byteenable;
   logic [DATA_W-1:0] ram_writedata;
   logic              ram_chipselect;
   logic              ram_write;
   logic              ram_clken;
   logic [DATA_W-1:0] ram_readdata;

   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output ram_address, ram_byteenable, ram_writedata, ram_chipselect, ram_write, ram_clken,
      input  ram_readdata
   );

   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  ram_address, ram_byteenable, ram_writedata, ram_chipselect, ram_write, ram_clken,
      output ram_readdata
   );
endinterface

// File: rtl/ethernet_sys_ram_arb_rr.sv
// Two-way round-robin picker with bounded burst hold for the current owner.
// Latency: purely combinational, decision in the same cycle.
// Backpressure: none; the caller gates the pick with freeze/ready.
// Ports: req (bit N = master N), state/burst_cnt/last_grant in; gnt_vld/gnt/next_state out.
module ethernet_sys_ram_arb_rr
   import ethernet_sys_ram_arb_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic [1:0] req,
   input  arb_state_t state,
   input  burst_cnt_t burst_cnt,
   input  mst_idx_t   last_grant,
   output logic       gnt_vld,
   output mst_idx_t   gnt,
   output arb_state_t next_state
);
   localparam burst_cnt_t MAX_BURST_C = burst_cnt_t'(MAX_BURST);

   logic     owned;
   logic     keep;
   mst_idx_t owner;

   always_comb begin
      gnt_vld    = |req;
      gnt        = M0;
      next_state = IDLE;
      owned      = (state == OWN_M0) || (state == OWN_M1);
      owner      = (state == OWN_M1) ? M1 : M0;
      // Owner keeps the RAM under contention until its burst allowance is spent.
      keep       = owned && (burst_cnt < MAX_BURST_C);
      if (req == 2'b11) begin
         gnt = keep ? owner : ((last_grant == M0) ? M1 : M0);
      end else if (req[1]) begin
         gnt = M1;
      end
      if (gnt_vld) begin
         next_state = (gnt == M1) ? OWN_M1 : OWN_M0;
      end
   end
endmodule

// File: rtl/ethernet_sys_ram_arbiter.sv
// Shares the single-port NIOS data RAM between M0 (NIOS) and M1 (Ethernet DMA), one access per cycle.
// Latency: grant combinational in the request cycle; read data returns exactly 1 cycle after issue.
// Backpressure: loser/unready/frozen master sees waitrequest=1; reset_req freezes all traffic.
// Ports: clk, reset_n (async active-low), reset_req, bus (slave modport of ethernet_sys_ram_arbiter_if).
// Optional ETHERNET_SYS_RAM_ARB_STATS_EN adds stat_clear, stat_grant_m0/m1 and stat_contend counters.
module ethernet_sys_ram_arbiter
   import ethernet_sys_ram_arb_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int BE_W      = 4,
   parameter int MAX_BURST = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        reset_req,
`ifdef ETHERNET_SYS_RAM_ARB_STATS_EN
   input  logic        stat_clear,
   output logic [31:0] stat_grant_m0,
   output logic [31:0] stat_grant_m1,
   output logic [31:0] stat_contend,
`endif
   ethernet_sys_ram_arbiter_if.slave bus
);
   logic       ready;
   arb_state_t state, state_d;
   burst_cnt_t burst_cnt, cnt_d;
   mst_idx_t   last_grant, last_d;
   logic [1:0] req;
   logic       pick_vld, issue, wr_sel;
   mst_idx_t   pick;
   arb_state_t pick_next;
   logic [RD_LATENCY-1:0] tag_vld;
   mst_idx_t   tag_own;

   logic [ADDR_W-1:0] sel_addr;
   logic [BE_W-1:0]   sel_be;
   logic [DATA_W-1:0] sel_wd;

   assign req = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};

   ethernet_sys_ram_arb_rr #(.MAX_BURST(MAX_BURST)) u_rr (
      .req        (req),
      .state      (state),
      .burst_cnt  (burst_cnt),
      .last_grant (last_grant),
      .gnt_vld    (pick_vld),
      .gnt        (pick),
      .next_state (pick_next)
   );

   assign issue = ready & ~reset_req & pick_vld;

   always_comb begin
      sel_addr = (pick == M1) ? bus.m1_address    : bus.m0_address;
      sel_be   = (pick == M1) ? bus.m1_byteenable : bus.m0_byteenable;
      sel_wd   = (pick == M1) ? bus.m1_writedata  : bus.m0_writedata;
      // Write wins when a master asserts read and write together.
      wr_sel   = (pick == M1) ? bus.m1_write      : bus.m0_write;
   end

   always_comb begin
      bus.m0_waitrequest = ~(issue && (pick == M0));
      bus.m1_waitrequest = ~(issue && (pick == M1));
      bus.ram_chipselect = issue;
      bus.ram_write      = issue & wr_sel;
      bus.ram_address    = issue ? sel_addr : '0;
      bus.ram_byteenable = issue ? sel_be   : '0;
      bus.ram_writedata  = issue ? sel_wd   : '0;
      // Gated by reset_n so every output reads 0 while reset is held.
      bus.ram_clken      = reset_n & ~reset_req;
      bus.m0_readdata    = reset_n ? bus.ram_readdata : '0;
      bus.m1_readdata    = reset_n ? bus.ram_readdata : '0;
      bus.m0_readdatavalid = tag_vld[RD_LATENCY-1] & (tag_own == M0);
      bus.m1_readdatavalid = tag_vld[RD_LATENCY-1] & (tag_own == M1);
   end

   // Next arbitration state; frozen (or not yet ready) cycles hold everything.
   always_comb begin
      state_d = state;
      cnt_d   = burst_cnt;
      last_d  = last_grant;
      if (ready && !reset_req) begin
         if (pick_vld) begin
            last_d  = pick;
            state_d = pick_next;
            if (pick_next == state) begin
               cnt_d = (burst_cnt == '1) ? burst_cnt : burst_cnt + burst_cnt_t'(1);
            end else begin
               cnt_d = burst_cnt_t'(1);
            end
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready      <= 1'b0;
         state      <= IDLE;
         burst_cnt  <= '0;
         last_grant <= M1;
         tag_vld    <= '0;
         tag_own    <= M0;
      end else begin
         ready      <= 1'b1;
         state      <= state_d;
         burst_cnt  <= cnt_d;
         last_grant <= last_d;
         // Tag is captured regardless of the freeze so a read issued just before it still returns.
         tag_vld[0] <= issue & ~wr_sel;
         tag_own    <= pick;
      end
   end

`ifdef ETHERNET_SYS_RAM_ARB_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_grant_m0 <= '0;
         stat_grant_m1 <= '0;
         stat_contend  <= '0;
      end else if (stat_clear) begin
         stat_grant_m0 <= '0;
         stat_grant_m1 <= '0;
         stat_contend  <= '0;
      end else begin
         if (issue && (pick == M0) && (stat_grant_m0 != '1)) stat_grant_m0 <= stat_grant_m0 + 32'd1;
         if (issue && (pick == M1) && (stat_grant_m1 != '1)) stat_grant_m1 <= stat_grant_m1 + 32'd1;
         if ((req == 2'b11) && !reset_req && (stat_contend != '1)) stat_contend <= stat_contend + 32'd1;
      end
   end
`endif

   a_m0_rd_wr : assert property (@(posedge clk) disable iff (!reset_n) !(bus.m0_read && bus.m0_write));
   a_m1_rd_wr : assert property (@(posedge clk) disable iff (!reset_n) !(bus.m1_read && bus.m1_write));

endmodule

// File: tb/tb_ethernet_sys_ram_arbiter.sv
// Directed bench for the NIOS data RAM arbiter with a behavioural 4096x32 RAM.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ethernet_sys_ram_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   logic reset_req;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   ethernet_sys_ram_arbiter_if #(.ADDR_W(12), .DATA_W(32), .BE_W(4)) bus ();

`ifdef ETHERNET_SYS_RAM_ARB_STATS_EN
   logic        stat_clear;
   logic [31:0] stat_grant_m0, stat_grant_m1, stat_contend;
`endif

   ethernet_sys_ram_arbiter #(.ADDR_W(12), .DATA_W(32), .BE_W(4), .MAX_BURST(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .reset_req (reset_req),
`ifdef ETHERNET_SYS_RAM_ARB_STATS_EN
      .stat_clear    (stat_clear),
      .stat_grant_m0 (stat_grant_m0),
      .stat_grant_m1 (stat_grant_m1),
      .stat_contend  (stat_contend),
`endif
      .bus       (bus)
   );

   // Behavioural single-port RAM with byte enables and clock enable, registered q.
   logic [31:0] mem [4096];
   logic [31:0] ram_q = '0;
   assign bus.ram_readdata = ram_q;
   always @(posedge clk) begin
      if (bus.ram_clken && bus.ram_chipselect) begin
         if (bus.ram_write) begin
            for (int b = 0; b < 4; b++)
               if (bus.ram_byteenable[b]) mem[bus.ram_address][b*8 +: 8] <= bus.ram_writedata[b*8 +: 8];
         end else begin
            ram_q <= mem[bus.ram_address];
         end
      end
   end

   typedef struct {
      logic        rr;
      logic        m0r, m0w; logic [11:0] m0a; logic [3:0] m0be; logic [31:0] m0d;
      logic        m1r, m1w; logic [11:0] m1a; logic [3:0] m1be; logic [31:0] m1d;
      logic        ew0, ew1, ev0, ev1, ecs, ewe, eck;
      logic [11:0] era; logic [3:0] ebe; logic [31:0] erd;
   } vec_t;

   vec_t tbl [7];

   bit t4_rr [12] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
   int t4_g  [12] = '{0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 1};

   function automatic logic [6:0] ctl_now();
      return {bus.m0_waitrequest, bus.m1_waitrequest, bus.m0_readdatavalid, bus.m1_readdatavalid,
              bus.ram_chipselect, bus.ram_write, bus.ram_clken};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Inputs are already driven; compare at the falling edge, then step past the next rising edge.
   task automatic check_out(input string nm, input logic [6:0] ectl, input logic [11:0] ra,
                            input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd);
      @(negedge clk);
      check({nm, " ctl"}, 64'(ctl_now()), 64'(ectl));
      if (ectl[2]) begin
         check({nm, " addr"}, 64'(bus.ram_address), 64'(ra));
         check({nm, " be"}, 64'(bus.ram_byteenable), 64'(be));
         if (ectl[1]) check({nm, " wdata"}, 64'(bus.ram_writedata), 64'(wd));
      end
      if (ectl[4]) check({nm, " m0_rdata"}, 64'(bus.m0_readdata), 64'(rd));
      if (ectl[3]) check({nm, " m1_rdata"}, 64'(bus.m1_readdata), 64'(rd));
      @(posedge clk);
      #1;
   endtask

   // Both masters read (M0 @0x010, M1 @0x020) when rq; eg/pg = expected grant this/prev cycle (2 = none).
   task automatic cyc(input string nm, input bit rq, input bit rr, input int eg, input int pg);
      logic [6:0] e;
      reset_req = rr;
      bus.m0_read = rq; bus.m0_write = 1'b0; bus.m0_address = 12'h010; bus.m0_byteenable = 4'hF; bus.m0_writedata = '0;
      bus.m1_read = rq; bus.m1_write = 1'b0; bus.m1_address = 12'h020; bus.m1_byteenable = 4'hF; bus.m1_writedata = '0;
      e = {eg != 0, eg != 1, pg == 0, pg == 1, eg != 2, 1'b0, !rr};
      check_out(nm, e, (eg == 1) ? 12'h020 : 12'h010, 4'hF, 32'h0,
                (pg == 0) ? 32'hDEADBEEF : 32'hAAAA3344);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pg;
      //        rr  m0r m0w m0a      m0be  m0d            m1r m1w m1a      m1be  m1d            w0  w1  v0  v1  cs  we  ck  ra       be    rd
      tbl[0] = '{'0, '0, '1, 12'h010, 4'hF, 32'hDEADBEEF, '0, '0, 12'h000, 4'h0, 32'h0,        '0, '1, '0, '0, '1, '1, '1, 12'h010, 4'hF, 32'h0};
      tbl[1] = '{'0, '1, '0, 12'h010, 4'hF, 32'h0,        '0, '0, 12'h000, 4'h0, 32'h0,        '0, '1, '0, '0, '1, '0, '1, 12'h010, 4'hF, 32'h0};
      tbl[2] = '{'0, '0, '0, 12'h000, 4'h0, 32'h0,        '0, '0, 12'h000, 4'h0, 32'h0,        '1, '1, '1, '0, '0, '0, '1, 12'h000, 4'h0, 32'hDEADBEEF};
      tbl[3] = '{'0, '0, '0, 12'h000, 4'h0, 32'h0,        '0, '1, 12'h020, 4'hF, 32'hAAAAAAAA, '1, '0, '0, '0, '1, '1, '1, 12'h020, 4'hF, 32'h0};
      tbl[4] = '{'0, '0, '0, 12'h000, 4'h0, 32'h0,        '0, '1, 12'h020, 4'h3, 32'h11223344, '1, '0, '0, '0, '1, '1, '1, 12'h020, 4'h3, 32'h0};
      tbl[5] = '{'0, '0, '0, 12'h000, 4'h0, 32'h0,        '1, '0, 12'h020, 4'hF, 32'h0,        '1, '0, '0, '0, '1, '0, '1, 12'h020, 4'hF, 32'h0};
      tbl[6] = '{'0, '0, '0, 12'h000, 4'h0, 32'h0,        '0, '0, 12'h000, 4'h0, 32'h0,        '1, '1, '0, '1, '0, '0, '1, 12'h000, 4'h0, 32'hAAAA3344};

      // Reset state, with a request present.
      reset_n = 1'b0; reset_req = 1'b0;
      bus.m0_read = 1'b1; bus.m0_write = 1'b0; bus.m0_address = 12'h010; bus.m0_byteenable = 4'hF; bus.m0_writedata = 32'h1;
      bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_writedata = '0;
`ifdef ETHERNET_SYS_RAM_ARB_STATS_EN
      stat_clear = 1'b0;
`endif
      @(negedge clk);
      check("rst ctl", 64'(ctl_now()), 64'(7'b1100000));
      check("rst addr", 64'(bus.ram_address), 64'h0);
      check("rst be", 64'(bus.ram_byteenable), 64'h0);
      check("rst wdata", 64'(bus.ram_writedata), 64'h0);
      check("rst m0_rdata", 64'(bus.m0_readdata), 64'h0);
      @(posedge clk); #1;

      // First cycle after release: ready flag not yet set.
      reset_n = 1'b1;
      cyc("release", 1'b1, 1'b0, 2, 2);

      // Write/read basics and byte-enable merge.
      for (int i = 0; i < 7; i++) begin
         reset_req = tbl[i].rr;
         bus.m0_read = tbl[i].m0r; bus.m0_write = tbl[i].m0w; bus.m0_address = tbl[i].m0a;
         bus.m0_byteenable = tbl[i].m0be; bus.m0_writedata = tbl[i].m0d;
         bus.m1_read = tbl[i].m1r; bus.m1_write = tbl[i].m1w; bus.m1_address = tbl[i].m1a;
         bus.m1_byteenable = tbl[i].m1be; bus.m1_writedata = tbl[i].m1d;
         check_out($sformatf("vec[%0d]", i),
                   {tbl[i].ew0, tbl[i].ew1, tbl[i].ev0, tbl[i].ev1, tbl[i].ecs, tbl[i].ewe, tbl[i].eck},
                   tbl[i].era, tbl[i].ebe, tbl[i].ew0 ? tbl[i].m1d : tbl[i].m0d, tbl[i].erd);
      end

      // Continuous contention: M0 x8, M1 x8, M0 x8, M1 x8 with no idle RAM cycle.
      pg = 2;
      for (int i = 0; i < 32; i++) begin
         cyc($sformatf("rr[%0d]", i), 1'b1, 1'b0, (i / 8) % 2, pg);
         pg = (i / 8) % 2;
      end
      cyc("rr tail", 1'b0, 1'b0, 2, pg);

      // Freeze for 3 cycles after two M0 grants; M0 then finishes its 8-grant burst.
      pg = 2;
      for (int i = 0; i < 12; i++) begin
         cyc($sformatf("frz[%0d]", i), 1'b1, t4_rr[i], t4_g[i], pg);
         pg = t4_g[i];
      end
      cyc("frz tail", 1'b0, 1'b0, 2, pg);

      // Reset with an M0 read in flight.
      cyc("rst2 a", 1'b1, 1'b0, 0, 2);
      cyc("rst2 b", 1'b1, 1'b0, 0, 0);
      check("rst2 inflight", 64'(bus.m0_readdatavalid), 64'h1);
      reset_n = 1'b0;
      #1;
      check("rst2 drop", 64'(ctl_now()), 64'(7'b1100000));
      @(posedge clk); #1;
      reset_n = 1'b1;
      cyc("rst2 notready", 1'b1, 1'b0, 2, 2);
      cyc("rst2 first", 1'b1, 1'b0, 0, 2);
      cyc("rst2 second", 1'b1, 1'b0, 0, 0);
      cyc("rst2 tail", 1'b0, 1'b0, 2, 0);

`ifdef ETHERNET_SYS_RAM_ARB_STATS_EN
      stat_clear = 1'b1;
      cyc("st clr0", 1'b0, 1'b0, 2, 2);
      stat_clear = 1'b0;
      // last_grant is M0 here, so M1 opens: M1 x8, M0 x8, M1 x4.
      pg = 2;
      for (int i = 0; i < 20; i++) begin
         cyc($sformatf("st[%0d]", i), 1'b1, 1'b0, (i < 8 || i >= 16) ? 1 : 0, pg);
         pg = (i < 8 || i >= 16) ? 1 : 0;
      end
      check("stat_contend", 64'(stat_contend), 64'd20);
      check("stat_sum", 64'(stat_grant_m0) + 64'(stat_grant_m1), 64'd20);
      check("stat_m0", 64'(stat_grant_m0), 64'd8);
      stat_clear = 1'b1;
      cyc("st clr1", 1'b0, 1'b0, 2, pg);
      stat_clear = 1'b0;
      check("stat cleared", {stat_contend, stat_grant_m0 | stat_grant_m1}, 64'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ethernet_sys_ram_arbiter.md
Name: ethernet_sys_ram_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares the single-port 4096x32 on-chip NIOS data RAM between the NIOS data master (M0) and the Ethernet packet DMA (M1).
- Performs round-robin with bounded burst hold and at most one RAM access per cycle.
- Returns read data with a fixed 1-cycle latency, tagged to the issuing master.
- Sits between the interconnect and the RAM wrapper and drives that wrapper's chipselect, write, byteenable and clken ports.

Parameters:
- ADDR_W, 12, word address width (4096 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- MAX_BURST, 8, consecutive grants one master may hold while the other is requesting (range 1..255)

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- reset_req  in  1  RAM clock-enable freeze request; stalls all traffic
- m0_address, m1_address  in  ADDR_W  word address
- m0_byteenable, m1_byteenable  in  BE_W  byte lanes
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_writedata, m1_writedata  in  DATA_W  write data
- m0_waitrequest, m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata, m1_readdata  out  DATA_W  read data
- m0_readdatavalid, m1_readdatavalid  out  1  read data valid
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  BE_W  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_clken  out  1  to RAM
- ram_readdata  in  DATA_W  RAM q, valid 1 cycle after issue

Behaviour:
- Request rule: reqN = mN_read | mN_write. If both read and write are asserted, the write wins; simulation assertion flags this case.
- Reset state: while reset_n=0, all outputs are 0 except m0_waitrequest=1 and m1_waitrequest=1.
- Reset release:
  - A registered ready flag sets on the first clk edge after reset_n rises.
  - Until that flag is set, waitrequests stay 1 and ram_chipselect stays 0.
- States: IDLE, OWN_M0, OWN_M1. The burst counter is 8-bit. last_grant resets to M1, so M0 wins the first tie.
- Grant, combinational within the cycle:
  - Only one master requesting: it wins.
  - Both requesting: the current owner keeps the grant while burst_cnt < MAX_BURST; otherwise the non-last_grant master wins.
- Issue: the winner gets waitrequest=0. The RAM ports carry the winner's address, byteenable and writedata, with ram_chipselect=1 and ram_write = winner's write. The loser gets waitrequest=1.
- Registered state update:
  - A grant to the same master increments burst_cnt.
  - A switch to the other master sets burst_cnt=1 and changes state.
  - No request: state goes to IDLE and burst_cnt=0.
  - last_grant is updated on every grant.
- Read return:
  - A 1-deep tag pipeline (valid, owner) captures each issued read.
  - In the next cycle, mN_readdatavalid=1 for the tagged owner, and mN_readdata = ram_readdata.
  - Both readdata outputs always mirror ram_readdata; the valid flags qualify them.
- Writes produce no readdatavalid.
- Freeze: ram_clken = ~reset_req. While reset_req=1:
  - No grant is made: both waitrequest=1, ram_chipselect=0.
  - State, burst_cnt and last_grant hold.
  - A read issued in the cycle before reset_req rose still returns its valid in the next cycle, because its address was latched while clken was high.
- Reset mid-operation: an in-flight read tag is cleared and its data is lost; no readdatavalid is ever produced for it.
- Throughput: one access per cycle; there are no dead cycles on an owner switch.

Optional Feature:
- Macro: ETHERNET_SYS_RAM_ARB_STATS_EN.
- When defined, adds these outputs:
  - stat_grant_m0 (32-bit)
  - stat_grant_m1 (32-bit)
  - stat_contend (32-bit): cycles in which both masters requested and reset_req=0
  - stat_clear (input, 1-bit): synchronous zero
- Counters saturate at 0xFFFFFFFF and reset to 0 on reset_n.
- When the macro is undefined, these ports and their logic are absent and the core behaviour is identical.

Decomposition:
- Package ethernet_sys_ram_arb_pkg holds:
  - the state enum (IDLE, OWN_M0, OWN_M1)
  - the master index type (M0 = 0, M1 = 1)
  - the constants RD_LATENCY = 1 and BURST_CNT_W = 8
- One sub-module, ethernet_sys_ram_arb_rr: the 2-way round-robin/burst-hold picker. It takes reqs, state, burst_cnt and last_grant and returns grant and next-state.

Test Plan:
1. M0 writes 0xDEADBEEF to word 0x010 with byteenable 0xF, then reads 0x010 with M1 idle → waitrequest=0 both cycles; m0_readdatavalid=1 with 0xDEADBEEF exactly 1 cycle after the read issue; m1_readdatavalid stays 0.
2. M0 and M1 both read continuously with MAX_BURST=8 → grants run M0×8, M1×8, M0×8…; no idle RAM cycles; each valid goes to the correct master.
3. Word 0x020 holds 0xAAAAAAAA; M1 writes 0x11223344 with byteenable 0x3; M1 reads it back → 0xAAAA3344.
4. Under contention, reset_req is held high for 3 cycles, one cycle after an M0 read issue → the M0 valid still arrives; then ram_clken=0, both waitrequest=1 and ram_chipselect=0 for 3 cycles; afterwards M0 resumes with burst_cnt preserved.
5. reset_n is pulsed low mid-burst with a read in flight → readdatavalid drops to 0 immediately and the in-flight read never returns; after release, waitrequest=1 for one cycle, then a simultaneous request is granted to M0.
6. With ETHERNET_SYS_RAM_ARB_STATS_EN defined: 20 contended cycles, then stat_clear → stat_contend=20 and stat_grant_m0 + stat_grant_m1 = 20; all counters read 0 the cycle after the clear.
